// File: rtl/mdu_divider_if.sv
// Handshake and operand/result bundle between the pipeline control and the divider.
// The master side issues requests and flushes; the slave side is the divider itself.
interface mdu_divider_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor, flush,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor, flush,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/mdu_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU: 32 CALC steps, one FIX step,
// then a one-cycle DONE pulse. Results are held in registers separate from the working state.
//
// state | meaning
// IDLE  | waiting for a request
// CALC  | one restoring step per clock, 32 steps
// FIX   | sign correction; results written on leaving this state
// DONE  | one cycle, done high; a new start is accepted here
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mdu_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [WIDTH:0]   rem_w;
  logic [WIDTH-1:0] quo_w;
  logic [WIDTH-1:0] dvsr;
  logic [5:0]       cnt;
  logic             sign_q;
  logic             sign_r;
  logic             dbz_w;

  logic             accept;
  logic             last_iter;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] mag_dividend;
  logic [WIDTH-1:0] mag_divisor;

  assign accept    = ((state == IDLE) || (state == DONE)) && bus.start && !bus.flush;
  assign last_iter = (cnt == 6'd31);

  // Busy and done decode straight from the state register, so they are
  // registered and mutually exclusive.
  assign bus.busy = (state == CALC) || (state == FIX);
  assign bus.done = (state == DONE);

  assign mag_dividend = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign mag_divisor  = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

  // Extra top bit keeps the trial difference sign unambiguous.
  assign shifted = {rem_w, quo_w[WIDTH-1]};
  assign diff    = shifted - {2'b00, dvsr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (last_iter) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = bus.start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_w  <= '0;
      quo_w  <= '0;
      dvsr   <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dbz_w  <= 1'b0;
    end else if (accept) begin
      rem_w  <= '0;
      quo_w  <= mag_dividend;
      dvsr   <= mag_divisor;
      cnt    <= '0;
      sign_q <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
      sign_r <= bus.is_signed & bus.dividend[WIDTH-1];
      dbz_w  <= (bus.divisor == '0);
    end else if (state == CALC) begin
      rem_w <= diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
      quo_w <= {quo_w[WIDTH-2:0], ~diff[WIDTH+1]};
      cnt   <= cnt + 6'd1;
    end
  end

  // Divide-by-zero forces an all-ones quotient even when the sign fix would
  // otherwise negate it; the remainder path already reproduces the dividend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else if ((state == FIX) && !bus.flush) begin
      bus.quotient    <= dbz_w ? '1 : (sign_q ? -quo_w : quo_w);
      bus.remainder   <= sign_r ? -rem_w[WIDTH-1:0] : rem_w[WIDTH-1:0];
      bus.div_by_zero <= dbz_w;
    end
  end

endmodule

// File: tb/tb_mdu_divider.sv
// Directed bench for mdu_divider: hand-computed DIV/DIVU results, latency,
// ignored start, back-to-back, flush and asynchronous reset.
module tb_mdu_divider;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   lat;
  int   bcnt;
  int   dcnt;

  mdu_divider_if bus ();

  mdu_divider u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from just after an edge; return edges from sampling edge
  // to done, and number of busy samples before done.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int l, output int bc);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    l  = 0;
    bc = 0;
    while (!bus.done && l < 40) begin
      if (bus.busy) bc++;
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic chk_res(input string tag, input logic [31:0] q, input logic [31:0] r,
                         input logic z);
    chk({tag, "_q"}, bus.quotient, q);
    chk({tag, "_r"}, bus.remainder, r);
    chk({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, z});
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.flush     = 1'b0;
    #12;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk_res("rst", 32'd0, 32'd0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // DIVU 100/7 with latency and busy length
    do_div(1'b0, 32'd100, 32'd7, lat, bcnt);
    chk("divu_lat", lat, 32'd33);
    chk("divu_busy_cycles", bcnt, 32'd33);
    chk("divu_busy_at_done", {31'd0, bus.busy}, 32'd0);
    chk_res("divu_100_7", 32'd14, 32'd2, 1'b0);
    @(posedge clk); #1;
    chk("done_pulse_one", {31'd0, bus.done}, 32'd0);
    chk("hold_q", bus.quotient, 32'd14);

    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
    chk_res("div_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk); #1;
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
    chk_res("div_7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0);
    @(posedge clk); #1;
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    chk_res("div_ovf", 32'h8000_0000, 32'd0, 1'b0);
    @(posedge clk); #1;
    do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    chk_res("divu_big", 32'd0, 32'h8000_0000, 1'b0);
    @(posedge clk); #1;
    do_div(1'b0, 32'd5, 32'd0, lat, bcnt);
    chk("dbz_lat", lat, 32'd33);
    chk_res("divu_5_0", 32'hFFFF_FFFF, 32'd5, 1'b1);
    @(posedge clk); #1;
    do_div(1'b0, 32'd9, 32'd3, lat, bcnt);
    chk_res("divu_9_3", 32'd3, 32'd0, 1'b0);
    @(posedge clk); #1;
    do_div(1'b1, 32'hFFFF_FFF8, 32'd0, lat, bcnt);
    chk_res("div_m8_0", 32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1);
    @(posedge clk); #1;

    // start pulsed mid-CALC must not disturb the operation in flight
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 6;
    while (!bus.done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("ign_lat", lat, 32'd33);
    chk_res("ign_start", 32'd14, 32'd2, 1'b0);

    // back-to-back: issue the next request in the DONE cycle
    do_div(1'b0, 32'd1000, 32'd3, lat, bcnt);
    chk("b2b_lat", lat, 32'd33);
    chk_res("b2b_1000_3", 32'd333, 32'd1, 1'b0);
    @(posedge clk); #1;

    // flush during iteration 10
    bus.start = 1'b1; bus.dividend = 32'd77; bus.divisor = 32'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    dcnt = 0;
    repeat (40) begin
      if (bus.done || bus.busy) dcnt++;
      @(posedge clk); #1;
    end
    chk("flush_no_done", dcnt, 32'd0);
    chk_res("flush_keep", 32'd333, 32'd1, 1'b0);

    // asynchronous reset during iteration 20
    bus.start = 1'b1; bus.dividend = 32'd77; bus.divisor = 32'd10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
    chk_res("mid_rst", 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_div(1'b0, 32'd100, 32'd7, lat, bcnt);
    chk("post_rst_lat", lat, 32'd33);
    chk_res("post_rst", 32'd14, 32'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
